// File: rtl/dma_rd_engine_if.sv
`default_nettype none
// =====================================================================
// dma_rd_engine_if : memory req/ack bus plus outbound valid/ready stream
// Rev 1.0
// =====================================================================
interface dma_rd_engine_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // master: the read engine; slave: memory plus downstream consumer
  modport master (
    output mem_req, mem_addr, out_valid, out_data,
    input  mem_ack, mem_rdata, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_data,
    output mem_ack, mem_rdata, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/dma_rd_engine.sv
`default_nettype none
// =====================================================================
// dma_rd_engine : fetches word_cnt words over req/ack, streams them out
//                 through a single output register. Optional ack
//                 watchdog enabled by macro DMA_RD_TIMEOUT_EN.
// Rev 1.0
// =====================================================================
module dma_rd_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
`ifdef DMA_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  word_cnt,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err,
  dma_rd_engine_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PUSH  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt,     w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data,    w_data_nxt;
  logic                  r_valid,   w_valid_nxt;
  logic                  r_req,     w_req_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  r_aborted, w_aborted_nxt;
  logic                  r_err,     w_err_nxt;
  logic                  w_timeout;

`ifdef DMA_RD_TIMEOUT_EN
  localparam int TO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W     = (TO_W_RAW < 8) ? 8 : ((TO_W_RAW > 16) ? 16 : TO_W_RAW);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_waiting;

  // mem_req is high exactly in REQ/DRAIN, so it doubles as the "waiting" qualifier
  assign w_waiting = r_req && !bus.mem_ack;
  assign w_timeout = w_waiting && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_waiting && !w_timeout) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_req_nxt     = r_req;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            w_addr_nxt  = {start_addr[ADDR_WIDTH-1:1], 1'b0};
            w_cnt_nxt   = word_cnt;
            w_req_nxt   = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end

      REQ: begin
        if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (abort) begin
          // an ack arriving with the abort completes the request; otherwise drain it
          if (bus.mem_ack) begin
            w_req_nxt     = 1'b0;
            w_aborted_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            w_state_nxt   = DRAIN;
          end
        end else if (bus.mem_ack) begin
          w_data_nxt  = bus.mem_rdata;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = PUSH;
        end
      end

      PUSH: begin
        if (abort) begin
          w_valid_nxt   = 1'b0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else if (r_valid && bus.out_ready) begin
          w_valid_nxt = 1'b0;
          w_addr_nxt  = r_addr + ADDR_WIDTH'(2);
          w_cnt_nxt   = r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_req_nxt   = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end

      DRAIN: begin
        if (w_timeout) begin
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (bus.mem_ack) begin
          w_req_nxt     = 1'b0;
          w_aborted_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_req     <= w_req_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign err           = r_err;
  assign bus.mem_req   = r_req;
  assign bus.mem_addr  = r_addr;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_engine.sv
`default_nettype none
// Bench for dma_rd_engine: random transfers against a queue/array reference
// of the expected address and word stream.
module tb_dma_rd_engine;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] word_cnt;
  logic          abort;
  logic          busy, done, aborted, err;

  dma_rd_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dma_rd_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
`ifdef DMA_RD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_cnt(word_cnt), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .err(err), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem [0:32767];
  logic [15:0] obs_data [$];
  logic [15:0] obs_addr [$];
  int          cnt_done, cnt_ab, cnt_err, req_cycles;
  int          ready_pct = 100;
  int          dly_min = 0;
  int          dly_max = 0;
  bit          mem_dead = 1'b0;
  int          wcnt = 0;
  bit          p_req = 1'b0, p_ack = 1'b0, p_val = 1'b0, p_rdy = 1'b0;
  logic [15:0] p_addr = '0, p_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick_dly();
    return int'($urandom_range(dly_max, dly_min));
  endfunction

  // memory responder: ack after a random wait, data from the memory array
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.mem_ack) begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        wcnt          = pick_dly();
      end else if (!bus.mem_req) begin
        bus.mem_rdata = 16'($urandom);
        wcnt          = pick_dly();
      end else if (!mem_dead) begin
        if (wcnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[AW-1:1]];
        end else begin
          wcnt--;
        end
      end
    end
  end

  // consumer
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.out_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
  end

  // monitor: samples the values the next rising edge will see
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_req = 1'b0; p_ack = 1'b0; p_val = 1'b0; p_rdy = 1'b0;
      end else begin
        if (bus.mem_req && p_req && !p_ack)
          check_eq("addr_hold", 32'(bus.mem_addr), 32'(p_addr));
        if (bus.out_valid && p_val && !p_rdy)
          check_eq("data_hold", 32'(bus.out_data), 32'(p_data));
        if (done || aborted || err)
          check_eq("pulse_excl", 32'(done) + 32'(aborted) + 32'(err), 32'd1);
        if (bus.out_valid && bus.out_ready && !abort) obs_data.push_back(bus.out_data);
        if (bus.mem_req && bus.mem_ack) obs_addr.push_back(bus.mem_addr);
        if (bus.mem_req) req_cycles++;
        if (done)    cnt_done++;
        if (aborted) cnt_ab++;
        if (err)     cnt_err++;
        p_req  = bus.mem_req;  p_ack  = bus.mem_ack;  p_addr = bus.mem_addr;
        p_val  = bus.out_valid; p_rdy = bus.out_ready; p_data = bus.out_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // One transfer; ab_mode 1 aborts at the ab_k-th request, 2 at the ab_k-th offered word.
  task automatic do_xfer(input string nm, input logic [15:0] a, input logic [15:0] n,
                         input int ab_mode, input int ab_k, input int hold,
                         input bit mid_start, output int cyc);
    int          req_seen, val_seen, hold_left, saved_pct;
    bit          fin, did_abort, drain_pend, lp_req, lp_val;
    logic [15:0] held, ea;
    obs_data.delete(); obs_addr.delete();
    cnt_done = 0; cnt_ab = 0; cnt_err = 0; req_cycles = 0;
    req_seen = 0; val_seen = 0; fin = 0; did_abort = 0; drain_pend = 0;
    lp_req = 0; lp_val = 0; hold_left = hold; saved_pct = ready_pct; held = '0;
    if (hold > 0) ready_pct = 0;
    @(negedge clk);
    start = 1'b1; start_addr = a; word_cnt = n;
    @(negedge clk);
    start = 1'b0; start_addr = 16'($urandom); word_cnt = 16'($urandom);
    cyc = 1;
    while (!fin && cyc < 3000) begin
      abort = 1'b0;
      start = 1'b0;
      if (done || aborted || err) begin
        fin = 1'b1;
        check_eq({nm, "_busy_end"}, 32'(busy), 32'd0);
      end else begin
        check_eq({nm, "_busy"}, 32'(busy), 32'd1);
        if (cyc == 1) check_eq({nm, "_first_req"}, 32'(bus.mem_req), 32'd1);
        if (drain_pend) check_eq({nm, "_drain_req"}, 32'(bus.mem_req), 32'd1);
        drain_pend = 1'b0;
        if (bus.mem_req && !lp_req) begin
          req_seen++;
          if (ab_mode == 1 && req_seen == ab_k) begin
            abort = 1'b1; did_abort = 1'b1; drain_pend = 1'b1;
          end
        end
        if (bus.out_valid && !lp_val) begin
          val_seen++;
          if (ab_mode == 2 && val_seen == ab_k) begin
            abort = 1'b1; did_abort = 1'b1;
          end
          if (mid_start && val_seen == 1) begin
            start = 1'b1; start_addr = 16'($urandom); word_cnt = 16'($urandom_range(9, 1));
          end
        end
        if (hold_left > 0 && bus.out_valid) begin
          if (hold_left == hold) held = bus.out_data;
          check_eq({nm, "_hold_data"}, 32'(bus.out_data), 32'(held));
          check_eq({nm, "_hold_noreq"}, 32'(bus.mem_req), 32'd0);
          hold_left--;
          if (hold_left == 0) ready_pct = saved_pct;
        end
        lp_req = bus.mem_req;
        lp_val = bus.out_valid;
        @(negedge clk);
        cyc++;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    ready_pct = saved_pct;
    if (!fin) check_eq({nm, "_xfer_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    check_eq({nm, "_err_cnt"}, 32'(cnt_err), 32'd0);
    if (did_abort) begin
      check_eq({nm, "_aborted_cnt"}, 32'(cnt_ab), 32'd1);
      check_eq({nm, "_done_cnt"}, 32'(cnt_done), 32'd0);
      check_eq({nm, "_nwords"}, 32'(obs_data.size()), 32'(ab_k - 1));
      check_eq({nm, "_naddr"}, 32'(obs_addr.size()), 32'(ab_k));
    end else begin
      check_eq({nm, "_done_cnt"}, 32'(cnt_done), 32'd1);
      check_eq({nm, "_aborted_cnt"}, 32'(cnt_ab), 32'd0);
      check_eq({nm, "_nwords"}, 32'(obs_data.size()), 32'(n));
      check_eq({nm, "_naddr"}, 32'(obs_addr.size()), 32'(n));
    end
    for (int i = 0; i < obs_addr.size() && i < int'(n); i++) begin
      ea = (a & 16'hFFFE) + 16'(2 * i);
      check_eq($sformatf("%s_addr%0d", nm, i), 32'(obs_addr[i]), 32'(ea));
    end
    for (int i = 0; i < obs_data.size() && i < int'(n); i++) begin
      ea = (a & 16'hFFFE) + 16'(2 * i);
      check_eq($sformatf("%s_data%0d", nm, i), 32'(obs_data[i]), 32'(mem[ea[15:1]]));
    end
  endtask

`ifdef DMA_RD_TIMEOUT_EN
  task automatic to_run(input string nm, input bit with_abort);
    int rc;
    bit fin;
    mem_dead = 1'b1;
    cnt_done = 0; cnt_ab = 0; cnt_err = 0;
    rc = 0; fin = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 16'h1234; word_cnt = 16'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      abort = 1'b0;
      if (err) begin
        fin = 1'b1;
      end else begin
        if (bus.mem_req) rc++;
        if (with_abort && c == 1) abort = 1'b1;
        @(negedge clk);
      end
    end
    abort = 1'b0;
    check_eq({nm, "_req_cycles"}, 32'(rc), 32'd8);
    check_eq({nm, "_busy"}, 32'(busy), 32'd0);
    check_eq({nm, "_req_low"}, 32'(bus.mem_req), 32'd0);
    check_eq({nm, "_valid_low"}, 32'(bus.out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check_eq({nm, "_err_cnt"}, 32'(cnt_err), 32'd1);
    check_eq({nm, "_ab_cnt"}, 32'(cnt_ab), 32'd0);
    check_eq({nm, "_done_cnt"}, 32'(cnt_done), 32'd0);
    mem_dead = 1'b0;
  endtask
`endif

  task automatic check_all_zero(input string nm);
    check_eq({nm, "_busy"}, 32'(busy), 32'd0);
    check_eq({nm, "_done"}, 32'(done), 32'd0);
    check_eq({nm, "_aborted"}, 32'(aborted), 32'd0);
    check_eq({nm, "_err"}, 32'(err), 32'd0);
    check_eq({nm, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check_eq({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({nm, "_out_data"}, 32'(bus.out_data), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    rst_n = 1'b0; start = 1'b0; start_addr = '0; word_cnt = '0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // abort while idle has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("idle_abort_pulse", 32'(aborted), 32'd0);
    check_eq("idle_abort_busy", 32'(busy), 32'd0);

    mem[16'h0100] = 16'hA001;
    mem[16'h0101] = 16'hA002;
    mem[16'h0102] = 16'hA003;
    dly_min = 0; dly_max = 0; ready_pct = 100;
    do_xfer("basic", 16'h0200, 16'd3, 0, 0, 0, 1'b0, cyc);
    check_eq("basic_latency", 32'(cyc), 32'd7);

    do_xfer("zero", 16'h0300, 16'd0, 0, 0, 0, 1'b0, cyc);
    check_eq("zero_latency", 32'(cyc), 32'd1);
    check_eq("zero_no_req", 32'(req_cycles), 32'd0);

    do_xfer("wrap", 16'hFFFF, 16'd2, 0, 0, 0, 1'b0, cyc);

    do_xfer("backpr", 16'h0810, 16'd3, 0, 0, 10, 1'b0, cyc);

    dly_min = 4; dly_max = 4;
    do_xfer("drain", 16'h2000, 16'd3, 1, 1, 0, 1'b0, cyc);
    dly_min = 1; dly_max = 1;
    do_xfer("after_drain", 16'h2100, 16'd3, 0, 0, 0, 1'b0, cyc);

    dly_min = 0; dly_max = 0; ready_pct = 100;
    do_xfer("abort_last", 16'h3000, 16'd1, 2, 1, 0, 1'b0, cyc);

    for (int t = 0; t < 12; t++) begin
      logic [15:0] a, n;
      int m, k;
      a = 16'($urandom);
      n = 16'($urandom_range(8, 1));
      dly_min = 0;
      dly_max = int'($urandom_range(3, 0));
      ready_pct = int'($urandom_range(100, 30));
      m = int'($urandom_range(2, 0));
      k = int'($urandom_range(int'(n), 1));
      do_xfer($sformatf("rnd%0d", t), a, n, m, k, 0, 1'($urandom_range(1, 0)), cyc);
    end

`ifdef DMA_RD_TIMEOUT_EN
    ready_pct = 100; dly_min = 0; dly_max = 1;
    to_run("tmo", 1'b0);
    to_run("tmo_abort", 1'b1);
    do_xfer("after_tmo", 16'h0400, 16'd2, 0, 0, 0, 1'b0, cyc);
`endif

    // asynchronous reset in the middle of a transfer
    ready_pct = 100; dly_min = 0; dly_max = 2;
    @(negedge clk);
    start = 1'b1; start_addr = 16'h4000; word_cnt = 16'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_mid_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    cnt_done = 0; cnt_ab = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_no_done", 32'(cnt_done), 32'd0);
    check_eq("rst_no_abort", 32'(cnt_ab), 32'd0);
    check_eq("rst_idle", 32'(busy), 32'd0);
    do_xfer("post_rst", 16'h5002, 16'd4, 0, 0, 0, 1'b0, cyc);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_rd_engine.md
Name: dma_rd_engine

Overview:
- Read-side companion to the DMA controller's configuration registers.
- Once started with a start address and word count, it fetches consecutive 16-bit words from memory over a req/ack handshake.
- Each fetched word is presented on a valid/ready stream toward the DMA write path.
- Holds exactly one word in an output register, so no word is lost under back-pressure.

Parameters:
- ADDR_WIDTH, 16, byte address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, memory word width.
- LEN_WIDTH, 16, width of word counter.
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with DMA_RD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a transfer when idle.
- start_addr  in  ADDR_WIDTH  first byte address; bit 0 is ignored (forced 0).
- word_cnt  in  LEN_WIDTH  number of words to read.
- abort  in  1  one-cycle pulse; cancels the transfer.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse; all words delivered.
- aborted  out  1  one-cycle pulse; transfer cancelled.
- err  out  1  one-cycle pulse; ack timeout (feature only).
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  read address; stable while mem_req is high.
- mem_ack  in  1  memory ack; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- out_valid  out  1  out_data holds a word.
- out_data  out  DATA_WIDTH  fetched word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - busy, done, aborted, err, mem_req, out_valid = 0.
  - mem_addr, out_data = 0; address and count registers = 0.
  - Reset mid-transfer drops everything immediately; no done or aborted pulse.
- States: IDLE, REQ, PUSH, DRAIN.
- IDLE:
  - start=1 with word_cnt!=0: latch {start_addr[AW-1:1],0} and word_cnt; next state REQ; mem_req=1 on the next cycle.
  - start=1 with word_cnt=0: done pulses next cycle; no memory access; stay IDLE.
  - start while not IDLE is ignored.
- REQ:
  - mem_req=1, mem_addr = current address.
  - On mem_ack: out_data <= mem_rdata, out_valid <= 1, mem_req <= 0, next state PUSH.
- PUSH:
  - On out_valid & out_ready: out_valid <= 0, address += 2 (wraps), count -= 1.
  - If the count before decrement was 1: done pulse next cycle, state IDLE, busy drops with done.
  - Otherwise: next state REQ.
- Throughput: at most one word per 2 cycles. Start-to-first-mem_req latency = 1 cycle.
- abort:
  - In PUSH: out_valid <= 0 (pending word discarded); aborted pulse next cycle; state IDLE.
  - In REQ: the handshake is never dropped mid-request. Go to DRAIN, hold mem_req until mem_ack, discard data, then pulse aborted and return to IDLE.
  - In IDLE: ignored.
  - abort coincident with the final out_ready handshake: abort wins; aborted pulses, not done.
- busy = (state != IDLE).
- done, aborted and err are mutually exclusive.

Optional Feature:
- Macro: DMA_RD_TIMEOUT_EN.
- With the macro:
  - An 8..16-bit counter increments each cycle mem_req=1 without mem_ack; it clears on ack or on leaving REQ/DRAIN.
  - When the count reaches TIMEOUT_CYCLES: mem_req <= 0, err pulse, state IDLE, out_valid = 0.
  - A timeout takes priority over a pending abort in DRAIN; err pulses, not aborted.
- Without the macro: err is tied to 0, no counter exists, and REQ/DRAIN wait indefinitely.

Test Plan:
- start_addr=0x0200, word_cnt=3, memory returns 0xA001/0xA002/0xA003 with ack 1 cycle after req, out_ready=1 -> mem_addr sequence 0x0200, 0x0202, 0x0204; out_data same three words in order; done exactly once; busy high throughout, low with done.
- word_cnt=0 -> done one cycle after start; mem_req never asserted.
- start_addr=0xFFFF, word_cnt=2 -> mem_addr 0xFFFE then 0x0000 (wrap, bit 0 cleared).
- out_ready held low 10 cycles after the first word -> out_valid and out_data stable; no second mem_req until the handshake; no data lost.
- abort while mem_req is high, ack delayed 4 cycles -> mem_req held until ack, data discarded, aborted pulse, no done; a following start works normally.
- DMA_RD_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_ack never asserted -> mem_req drops after 8 cycles, err pulses once, busy falls. Mid-transfer rst_n low -> all outputs 0 asynchronously.
